// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer arbiter.
// It also holds the bank-select rule for filter accesses.
package fb_pkg;

    localparam int FB_ADDR_W = 16;
    localparam int FB_DATA_W = 8;

    typedef enum logic {
        S_RUN,
        S_SWAP_PEND
    } fb_state_t;

    typedef enum logic {
        OWN_DISP,
        OWN_FLT
    } fb_owner_t;

    // Only filter reads may look at the shown bank; everything else hits the back bank.
    function automatic logic flt_bank_sel(input logic front, input logic src, input logic we);
        return (src & ~we) ? front : ~front;
    endfunction

endpackage

// File: rtl/fb_swap_ctrl.sv
// Swap controller: vsync falling-edge detect, swap FSM and the shown-bank register.
// A requested swap takes effect only on a vsync fall seen while already pending.
module fb_swap_ctrl
    import fb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic vsync_i,
    input  logic frame_done_i,
    output logic run_o,
    output logic swap_pending_o,
    output logic front_bank_o,
    output logic frame_swapped_o
);

    fb_state_t state_q, state_d;
    logic      vs_q;
    logic      front_bank_q, front_bank_d;
    logic      swap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RUN;
            vs_q         <= 1'b1;
            front_bank_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vsync_i;
            front_bank_q <= front_bank_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        front_bank_d = front_bank_q;
        swap         = 1'b0;
        case (state_q)
            S_RUN: begin
                // A vsync fall in this same cycle is deliberately not acted on.
                if (frame_done_i) state_d = S_SWAP_PEND;
            end
            S_SWAP_PEND: begin
                if (vs_q & ~vsync_i) begin
                    state_d      = S_RUN;
                    front_bank_d = ~front_bank_q;
                    swap         = 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    assign run_o           = (state_q == S_RUN);
    assign swap_pending_o  = (state_q == S_SWAP_PEND);
    assign front_bank_o    = front_bank_q;
    assign frame_swapped_o = swap;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win, filter takes idle cycles.
// Double-buffered banks swap on vsync fall; read data returns one cycle after issue.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vsync,
    input  logic              disp_rd_en,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rd_data,
    output logic              disp_rd_valid,
    input  logic              flt_req,
    input  logic              flt_we,
    input  logic              flt_src,
    input  logic [ADDR_W-1:0] flt_addr,
    input  logic [DATA_W-1:0] flt_wdata,
    output logic              flt_gnt,
    output logic [DATA_W-1:0] flt_rd_data,
    output logic              flt_rd_valid,
    input  logic              flt_frame_done,
    output logic              flt_swap_pending,
    output logic              front_bank,
    output logic              frame_swapped,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic      run;
    logic      rd_vld_q, rd_vld_d;
    fb_owner_t rd_own_q, rd_own_d;

    fb_swap_ctrl u_swap (
        .clk            (clk),
        .rst            (rst),
        .vsync_i        (i_vsync),
        .frame_done_i   (flt_frame_done),
        .run_o          (run),
        .swap_pending_o (flt_swap_pending),
        .front_bank_o   (front_bank),
        .frame_swapped_o(frame_swapped)
    );

    assign flt_gnt = flt_req & ~disp_rd_en & run;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (disp_rd_en) begin
            mem_en   = 1'b1;
            mem_addr = {front_bank, disp_addr};
        end else if (flt_gnt) begin
            mem_en    = 1'b1;
            mem_we    = flt_we;
            mem_wdata = flt_wdata;
            mem_addr  = {flt_bank_sel(front_bank, flt_src, flt_we), flt_addr};
        end
    end

    // The bank is part of mem_addr at issue, so a read straddling a swap stays coherent.
    always_comb begin
        rd_vld_d = disp_rd_en | (flt_gnt & ~flt_we);
        rd_own_d = disp_rd_en ? OWN_DISP : OWN_FLT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_own_q <= OWN_DISP;
        end else begin
            rd_vld_q <= rd_vld_d;
            rd_own_q <= rd_own_d;
        end
    end

    assign disp_rd_valid = rd_vld_q & (rd_own_q == OWN_DISP);
    assign flt_rd_valid  = rd_vld_q & (rd_own_q == OWN_FLT);
    assign disp_rd_data  = disp_rd_valid ? mem_rdata : '0;
    assign flt_rd_data   = flt_rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios then random traffic, checked every cycle
// against a bank/pending/shadow-memory model plus an attached BRAM.
module tb_fb_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_vsync;
    logic          disp_rd_en;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_rd_data;
    logic          disp_rd_valid;
    logic          flt_req, flt_we, flt_src;
    logic [AW-1:0] flt_addr;
    logic [DW-1:0] flt_wdata;
    logic          flt_gnt;
    logic [DW-1:0] flt_rd_data;
    logic          flt_rd_valid;
    logic          flt_frame_done;
    logic          flt_swap_pending;
    logic          front_bank;
    logic          frame_swapped;
    logic          mem_en, mem_we;
    logic [AW:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .i_vsync(i_vsync),
        .disp_rd_en(disp_rd_en), .disp_addr(disp_addr),
        .disp_rd_data(disp_rd_data), .disp_rd_valid(disp_rd_valid),
        .flt_req(flt_req), .flt_we(flt_we), .flt_src(flt_src),
        .flt_addr(flt_addr), .flt_wdata(flt_wdata), .flt_gnt(flt_gnt),
        .flt_rd_data(flt_rd_data), .flt_rd_valid(flt_rd_valid),
        .flt_frame_done(flt_frame_done), .flt_swap_pending(flt_swap_pending),
        .front_bank(front_bank), .frame_swapped(frame_swapped),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram    [0:(1<<(AW+1))-1];
    logic [DW-1:0] shadow [0:(1<<(AW+1))-1];

    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
            else                 mem_rdata     <= ram[mem_addr];
        end
    end

    function automatic logic [DW-1:0] pat(input int i);
        return DW'(i * 7 + (i >> 9));
    endfunction

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit            m_front, m_pend, m_vsp;
    bit            e_dv, e_fv, e_gnt, e_swap, fb;
    logic [DW-1:0] e_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic eval();
        @(negedge clk);
        if (!rst) begin
            e_swap = m_pend && m_vsp && !i_vsync;
            e_gnt  = flt_req && !disp_rd_en && !m_pend;
            fb     = (flt_src && !flt_we) ? m_front : !m_front;
            chk("flt_gnt", flt_gnt, e_gnt);
            chk("swap_pending", flt_swap_pending, m_pend);
            chk("front_bank", front_bank, m_front);
            chk("frame_swapped", frame_swapped, e_swap);
            chk("disp_rd_valid", disp_rd_valid, e_dv);
            chk("flt_rd_valid", flt_rd_valid, e_fv);
            if (e_dv) chk("disp_rd_data", disp_rd_data, e_data);
            if (e_fv) chk("flt_rd_data", flt_rd_data, e_data);
            chk("mem_en", mem_en, disp_rd_en || e_gnt);
            if (disp_rd_en) begin
                chk("mem_we_disp", mem_we, 0);
                chk("mem_addr_disp", mem_addr, {m_front, disp_addr});
            end else if (e_gnt) begin
                chk("mem_we_flt", mem_we, flt_we);
                chk("mem_addr_flt", mem_addr, {fb, flt_addr});
                if (flt_we) chk("mem_wdata", mem_wdata, flt_wdata);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) begin
            m_front = 0; m_pend = 0; m_vsp = 1; e_dv = 0; e_fv = 0;
        end else begin
            e_dv = disp_rd_en;
            e_fv = e_gnt && !flt_we;
            if (disp_rd_en) e_data = shadow[{m_front, disp_addr}];
            else if (e_fv)  e_data = shadow[{fb, flt_addr}];
            if (e_gnt && flt_we) shadow[{fb, flt_addr}] = flt_wdata;
            m_front = m_front ^ e_swap;
            m_pend  = e_swap ? 1'b0 : (m_pend || flt_frame_done);
            m_vsp   = i_vsync;
        end
        #1;
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    initial begin
        bit granted_last;
        for (int i = 0; i < (1 << (AW + 1)); i++) begin
            ram[i] = pat(i);
            shadow[i] = pat(i);
        end
        rst = 1; i_vsync = 1; disp_rd_en = 1; disp_addr = '0;
        flt_req = 1; flt_we = 0; flt_src = 0; flt_addr = '0; flt_wdata = '0;
        flt_frame_done = 1;
        repeat (3) step();

        // Post-reset idle cycle: everything quiet
        rst = 0; disp_rd_en = 0; flt_req = 0; flt_frame_done = 0;
        eval();
        chk("rst_front", front_bank, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_gnt", flt_gnt, 0);
        chk("rst_dvalid", disp_rd_valid, 0);
        chk("rst_fvalid", flt_rd_valid, 0);
        chk("rst_pending", flt_swap_pending, 0);
        chk("rst_swapped", frame_swapped, 0);
        adv();

        // Collision: display holds the port for four cycles
        disp_rd_en = 1; disp_addr = 16'h0100;
        flt_req = 1; flt_we = 0; flt_src = 0; flt_addr = 16'h0010;
        for (int k = 0; k < 4; k++) begin
            eval();
            chk("coll_gnt_blocked", flt_gnt, 0);
            if (k > 0) chk("coll_disp_valid", disp_rd_valid, 1);
            adv();
        end
        disp_rd_en = 0;
        eval(); chk("coll_gnt_cycle5", flt_gnt, 1); chk("coll_disp_valid4", disp_rd_valid, 1); adv();
        flt_req = 0;
        eval(); chk("coll_fvalid6", flt_rd_valid, 1); chk("coll_fdata6", flt_rd_data, pat(32'h10010)); adv();

        // Write with src=1 is still forced into the back bank
        flt_req = 1; flt_we = 1; flt_src = 1; flt_addr = 16'h1234; flt_wdata = 8'hA5;
        eval(); chk("wr_addr", mem_addr, 17'h11234); chk("wr_we", mem_we, 1); adv();
        flt_we = 0; flt_src = 0;
        eval(); adv();
        flt_req = 0;
        eval(); chk("wr_readback", flt_rd_data, 8'hA5); adv();

        // Swap request, then vsync fall
        flt_req = 1; flt_addr = 16'h0005; flt_frame_done = 1;
        step();
        flt_frame_done = 0;
        eval(); chk("sw_pending", flt_swap_pending, 1); chk("sw_gnt_held", flt_gnt, 0); adv();
        repeat (2) step();
        i_vsync = 0;
        eval(); chk("sw_swapped", frame_swapped, 1); chk("sw_gnt_swapcyc", flt_gnt, 0); adv();
        eval(); chk("sw_front1", front_bank, 1); chk("sw_gnt_after", flt_gnt, 1); chk("sw_pulse_once", frame_swapped, 0); adv();
        flt_req = 0;
        repeat (2) step();
        i_vsync = 1;
        repeat (2) step();

        // frame_done coincident with a vsync fall waits a frame; extra frame_done ignored
        flt_frame_done = 1; i_vsync = 0;
        eval(); chk("sim_no_swap", frame_swapped, 0); adv();
        flt_frame_done = 0;
        step();
        i_vsync = 1; step();
        flt_frame_done = 1; step();
        flt_frame_done = 0; step();
        i_vsync = 0;
        eval(); chk("sim_swap", frame_swapped, 1); adv();
        eval(); chk("sim_front0", front_bank, 0); chk("sim_pend_clr", flt_swap_pending, 0); adv();
        i_vsync = 1; repeat (2) step();
        i_vsync = 0;
        eval(); chk("sim_no_double", frame_swapped, 0); adv();
        i_vsync = 1; step();

        // Filter front-bank read issued just before the swap edge
        flt_req = 1; flt_we = 0; flt_src = 1; flt_addr = 16'h0020; flt_frame_done = 1;
        eval(); chk("xs_gnt", flt_gnt, 1); adv();
        flt_req = 0; flt_frame_done = 0; i_vsync = 0;
        eval();
        chk("xs_swapped", frame_swapped, 1);
        chk("xs_fvalid", flt_rd_valid, 1);
        chk("xs_fdata", flt_rd_data, pat(32'h00020));
        chk("xs_no_dvalid", disp_rd_valid, 0);
        adv();
        eval(); chk("xs_front1", front_bank, 1); adv();
        i_vsync = 1; step();

        // Reset mid-transaction drops the pending swap and in-flight read
        flt_frame_done = 1; step();
        flt_frame_done = 0; disp_rd_en = 1; disp_addr = 16'h0042; step();
        rst = 1; step();
        rst = 0; disp_rd_en = 0;
        eval();
        chk("mrst_pending", flt_swap_pending, 0);
        chk("mrst_front", front_bank, 0);
        chk("mrst_dvalid", disp_rd_valid, 0);
        adv();

        // Random traffic
        granted_last = 1;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 999) == 0);
            disp_rd_en = $urandom_range(0, 1);
            disp_addr = AW'($urandom_range(0, 31));
            if (!flt_req || granted_last) begin
                flt_req   = ($urandom_range(0, 2) != 0);
                flt_we    = $urandom_range(0, 1);
                flt_src   = $urandom_range(0, 1);
                flt_addr  = AW'($urandom_range(0, 31));
                flt_wdata = DW'($urandom);
            end
            if (rst) begin
                flt_req = 0;
                disp_rd_en = 0;
            end
            i_vsync = ($urandom_range(0, 9) != 0);
            flt_frame_done = ($urandom_range(0, 15) == 0);
            eval();
            granted_last = e_gnt && !rst;
            adv();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
